ival_packer: RTL and testbench
==============================

// Module: ival_packer
// PURPOSE
//  Upstream feeder for the ival capture stage. Packs a stream of bytes into
//  32-bit ival words and presents them with a valid/ready handshake. The
//  first byte of a word lands in ival[31:24], so the capture stage's top-bit
//  slices see the oldest data. An early in_last flushes a partial word,
//  padding the remaining bytes.
// PARAMETERS
//  BYTES_PER_WORD  4      bytes per output word; ival width = 8*BYTES_PER_WORD
//  PAD_BYTE        8'h00  fill value for unused low bytes of a flushed partial word
// PORTS
//  sysclk     in   1    single clock, all logic on posedge
//  reset      in   1    synchronous reset, active-high
//  in_data    in   8    input byte
//  in_valid   in   1    in_data valid
//  in_last    in   1    with in_valid: final byte of a packet, flush word
//  in_ready   out  1    byte accepted on a cycle where in_valid && in_ready
//  ival       out  32   packed word, held stable while out_valid && !out_ready
//  out_valid  out  1    ival valid
//  out_ready  in   1    downstream accepts ival on out_valid && out_ready
//  out_count  out  3    number of valid bytes in ival, 1..4
//  out_last   out  1    word closed by in_last
// BEHAVIOUR
//  - Reset (sync, sysclk edge with reset=1) clears the following:
//    - ival=0, out_valid=0, out_count=0, out_last=0.
//    - Accumulator count=0, accumulator data=PAD bytes.
//    - in_ready is 0 during reset and 1 on the first cycle after reset.
//  - Reset mid-word discards the partial accumulator and any held ival.
//  - Byte acceptance:
//    - in_ready = !out_valid || out_ready. This is combinational from
//      out_ready and does not depend on in_valid.
//  - States:
//    - FILL (count 0..3): collecting bytes.
//    - HOLD: out_valid=1, waiting for downstream.
//    - The state is implied by count and out_valid.
//  - On an accepted byte with count=k:
//    - The byte is written to accumulator slot k (bits 31-8k : 24-8k).
//    - count increments.
//  - A word closes when the accepted byte makes count=4, or the accepted
//    byte has in_last=1. On the same edge:
//    - ival <= accumulator including this byte.
//    - Unfilled slots are set to PAD_BYTE.
//    - out_count <= k+1, out_last <= in_last, out_valid <= 1.
//    - The accumulator resets to count=0.
//  - Latency: ival is valid the cycle after the closing byte is accepted.
//    Sustained rate is 1 byte/cycle while out_ready=1.
//  - Output handshake:
//    - On out_valid && out_ready, out_valid drops unless a new word closes
//      on the same edge. If it closes, the new word replaces the old one
//      with no bubble.
//    - ival, out_count and out_last are unchanged while out_valid && !out_ready.
//  - in_last on the 4th byte gives out_count=4, out_last=1.
//  - in_last with in_valid=0 is ignored.
//  - in_data, in_last and in_par are don't-care when in_valid=0.
// CONFIGURATION
//  PARITY_CHECK_EN defined:
//   - Adds input in_par (1 bit), odd parity over in_data.
//   - Adds output out_perr (1 bit, reset 0). out_perr is set with the word
//     when any byte accepted into that word had bad parity.
//   - out_perr follows the same hold rules as ival.
//  PARITY_CHECK_EN undefined:
//   - in_par and out_perr do not exist. No parity logic is built.
// TESTING
//  1. Feed bytes 11,22,33,44 on consecutive cycles with out_ready=1.
//     -> ival=32'h11223344, out_count=4, out_last=0, one cycle after byte 44.
//  2. Feed 8 bytes 01..08 back to back with out_ready=1.
//     -> words 01020304 then 05060708, in_ready stays 1 throughout.
//  3. Feed AA, BB with in_last on BB, PAD_BYTE=0.
//     -> ival=32'hAABB0000, out_count=2, out_last=1.
//  4. Complete a word with out_ready=0 for 5 cycles.
//     -> in_ready=0, ival stable, no bytes lost. Accept resumes the cycle
//        out_ready=1.
//  5. Assert reset after 2 bytes, then feed C1..C4.
//     -> ival=32'hC1C2C3C4, out_count=4. Pre-reset bytes absent.
//  6. PARITY_CHECK_EN: set bad in_par on the 3rd byte of a word.
//     -> out_perr=1 for that word only. The next clean word gives out_perr=0.

Source files
------------

// File: rtl/ival_packer_if.sv
// Byte-in / word-out handshake bundle for ival_packer.
// PARITY_CHECK_EN adds in_par and out_perr.
interface ival_packer_if #(
    parameter int BYTES_PER_WORD = 4
);
    localparam int CW = $clog2(BYTES_PER_WORD + 1);

    logic [7:0]                  in_data;
    logic                        in_valid;
    logic                        in_last;
    logic                        in_ready;
    logic [8*BYTES_PER_WORD-1:0] ival;
    logic                        out_valid;
    logic                        out_ready;
    logic [CW-1:0]               out_count;
    logic                        out_last;
`ifdef PARITY_CHECK_EN
    logic                        in_par;
    logic                        out_perr;
`endif

    modport master (
        output in_data, in_valid, in_last, out_ready,
`ifdef PARITY_CHECK_EN
        output in_par,
        input  out_perr,
`endif
        input  in_ready, ival, out_valid, out_count, out_last
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
`ifdef PARITY_CHECK_EN
        input  in_par,
        output out_perr,
`endif
        output in_ready, ival, out_valid, out_count, out_last
    );
endinterface

// File: rtl/ival_packer.sv
// Packs a byte stream into ival words, oldest byte in the top slot; in_last flushes a
// padded partial word. Optional odd-parity checking under PARITY_CHECK_EN.
module ival_packer #(
    parameter int         BYTES_PER_WORD = 4,
    parameter logic [7:0] PAD_BYTE       = 8'h00
) (
    input logic          sysclk,
    input logic          reset,
    ival_packer_if.slave bus
);
    localparam int CW = $clog2(BYTES_PER_WORD + 1);

    logic [BYTES_PER_WORD-1:0][7:0] acc;
    logic [BYTES_PER_WORD-1:0][7:0] word;
    logic [CW-1:0]                  cnt;
    logic                           accept;
    logic                           close;

    // Output slot freed this cycle (empty, or being taken) lets a byte in.
    assign bus.in_ready = !reset && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign close        = accept && (bus.in_last || cnt == CW'(BYTES_PER_WORD - 1));

    // Slot k sits at packed index BYTES_PER_WORD-1-k; unfilled slots already hold PAD.
    for (genvar i = 0; i < BYTES_PER_WORD; i++) begin : g_slot
        assign word[BYTES_PER_WORD-1-i] = (cnt == CW'(i)) ? bus.in_data : acc[BYTES_PER_WORD-1-i];
    end

`ifdef PARITY_CHECK_EN
    logic perr_acc;
    logic bad_par;
    assign bad_par = ~^{bus.in_data, bus.in_par};
`endif

    always_ff @(posedge sysclk) begin
        if (reset) begin
            acc           <= {BYTES_PER_WORD{PAD_BYTE}};
            cnt           <= '0;
            bus.ival      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_count <= '0;
            bus.out_last  <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_acc      <= 1'b0;
            bus.out_perr  <= 1'b0;
`endif
        end else begin
            if (bus.out_valid && bus.out_ready)
                bus.out_valid <= 1'b0;
            if (close) begin
                bus.ival      <= word;
                bus.out_count <= cnt + CW'(1);
                bus.out_last  <= bus.in_last;
                bus.out_valid <= 1'b1;
                acc           <= {BYTES_PER_WORD{PAD_BYTE}};
                cnt           <= '0;
`ifdef PARITY_CHECK_EN
                bus.out_perr  <= perr_acc | bad_par;
                perr_acc      <= 1'b0;
`endif
            end else if (accept) begin
                acc <= word;
                cnt <= cnt + CW'(1);
`ifdef PARITY_CHECK_EN
                perr_acc <= perr_acc | bad_par;
`endif
            end
        end
    end
endmodule

// File: tb/tb_ival_packer.sv
// Directed table-driven bench for ival_packer; parity sequence runs when PARITY_CHECK_EN is defined.
module tb_ival_packer;
    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    always #5 sysclk = ~sysclk;

    ival_packer_if #(.BYTES_PER_WORD(4)) bus ();

    ival_packer #(.BYTES_PER_WORD(4), .PAD_BYTE(8'h00)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus.slave)
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        rdy;
        logic        bad;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_ival;
        logic [2:0]  e_cnt;
        logic        e_last;
        logic        e_perr;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic v, logic [7:0] d, logic l, logic rdy,
                                logic e_ir, logic e_ov, logic [31:0] e_ival,
                                logic [2:0] e_cnt, logic e_last);
        vec_t t;
        t.rst = rst; t.v = v; t.d = d; t.l = l; t.rdy = rdy; t.bad = 1'b0;
        t.e_ir = e_ir; t.e_ov = e_ov; t.e_ival = e_ival; t.e_cnt = e_cnt;
        t.e_last = e_last; t.e_perr = 1'b0;
        return t;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive on negedge, check in_ready combinationally, then check registered outputs after posedge.
    task automatic apply(vec_t t, int idx);
        @(negedge sysclk);
        reset        = t.rst;
        bus.in_valid = t.v;
        bus.in_data  = t.d;
        bus.in_last  = t.l;
        bus.out_ready = t.rdy;
`ifdef PARITY_CHECK_EN
        bus.in_par   = (~^t.d) ^ t.bad;
`endif
        #1;
        chk("in_ready", idx, {31'd0, bus.in_ready}, {31'd0, t.e_ir});
        @(posedge sysclk);
        #1;
        chk("out_valid", idx, {31'd0, bus.out_valid}, {31'd0, t.e_ov});
        if (t.rst) begin
            chk("rst_ival", idx, bus.ival, 32'h0);
            chk("rst_count", idx, {29'd0, bus.out_count}, 32'd0);
            chk("rst_last", idx, {31'd0, bus.out_last}, 32'd0);
        end
        if (t.e_ov) begin
            chk("ival", idx, bus.ival, t.e_ival);
            chk("out_count", idx, {29'd0, bus.out_count}, {29'd0, t.e_cnt});
            chk("out_last", idx, {31'd0, bus.out_last}, {31'd0, t.e_last});
`ifdef PARITY_CHECK_EN
            chk("out_perr", idx, {31'd0, bus.out_perr}, {31'd0, t.e_perr});
`endif
        end
    endtask

    initial begin
        vec_t t;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0; bus.out_ready = 1'b0;
`ifdef PARITY_CHECK_EN
        bus.in_par = 1'b1;
`endif
        repeat (2) @(posedge sysclk);

        // reset state, then test 1
        tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h11, 0, 1, 1, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h22, 0, 1, 1, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h33, 0, 1, 1, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h44, 0, 1, 1, 1, 32'h11223344, 4, 0));
        // test 2: back to back, in_ready stays 1
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(0, 1, 8'(i), 0, 1, 1, (i % 4 == 0),
                             (i == 4) ? 32'h01020304 : 32'h05060708, 4, 0));
        // test 3: early flush with padding
        tbl.push_back(mk(0, 1, 8'hAA, 0, 1, 1, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hBB, 1, 1, 1, 1, 32'hAABB0000, 2, 1));
        // in_last without in_valid ignored
        tbl.push_back(mk(0, 0, 8'h99, 1, 1, 1, 0, 32'h0, 0, 0));
        // single-byte words: second replaces first with no bubble, third blocked while held
        tbl.push_back(mk(0, 1, 8'hF1, 1, 1, 1, 1, 32'hF1000000, 1, 1));
        tbl.push_back(mk(0, 1, 8'hF2, 1, 1, 1, 1, 32'hF2000000, 1, 1));
        tbl.push_back(mk(0, 1, 8'h77, 1, 0, 0, 1, 32'hF2000000, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 32'h0, 0, 0));
        // in_last on 4th byte
        tbl.push_back(mk(0, 1, 8'h91, 0, 1, 1, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h92, 0, 1, 1, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h93, 0, 1, 1, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h94, 1, 1, 1, 1, 32'h91929394, 4, 1));
        // test 5: reset mid-word
        tbl.push_back(mk(0, 1, 8'h5A, 0, 1, 1, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h5B, 0, 1, 1, 0, 32'h0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h5C, 0, 1, 0, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hC1, 0, 1, 1, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hC2, 0, 1, 1, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hC3, 0, 1, 1, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hC4, 0, 0, 1, 1, 32'hC1C2C3C4, 4, 0));
        // reset discards a held word
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 32'h0, 0, 0));

        foreach (tbl[i]) apply(tbl[i], i);

        // test 4: word completes with out_ready=0, held for 5 cycles, then resumes
        apply(mk(0, 1, 8'hD1, 0, 0, 1, 0, 32'h0, 0, 0), 100);
        apply(mk(0, 1, 8'hD2, 0, 0, 1, 0, 32'h0, 0, 0), 101);
        apply(mk(0, 1, 8'hD3, 0, 0, 1, 0, 32'h0, 0, 0), 102);
        apply(mk(0, 1, 8'hD4, 0, 0, 1, 1, 32'hD1D2D3D4, 4, 0), 103);
        for (int i = 0; i < 5; i++)
            apply(mk(0, 1, 8'hE1, 0, 0, 0, 1, 32'hD1D2D3D4, 4, 0), 110 + i);
        apply(mk(0, 1, 8'hE1, 0, 1, 1, 0, 32'h0, 0, 0), 120);
        apply(mk(0, 1, 8'hE2, 0, 1, 1, 0, 32'h0, 0, 0), 121);
        apply(mk(0, 1, 8'hE3, 0, 1, 1, 0, 32'h0, 0, 0), 122);
        apply(mk(0, 1, 8'hE4, 0, 1, 1, 1, 32'hE1E2E3E4, 4, 0), 123);

`ifdef PARITY_CHECK_EN
        // test 6: bad parity on the 3rd byte flags only that word
        apply(mk(0, 1, 8'h31, 0, 1, 1, 0, 32'h0, 0, 0), 200);
        apply(mk(0, 1, 8'h32, 0, 1, 1, 0, 32'h0, 0, 0), 201);
        t = mk(0, 1, 8'h33, 0, 1, 1, 0, 32'h0, 0, 0);
        t.bad = 1'b1;
        apply(t, 202);
        t = mk(0, 1, 8'h34, 0, 1, 1, 1, 32'h31323334, 4, 0);
        t.e_perr = 1'b1;
        apply(t, 203);
        apply(mk(0, 1, 8'h41, 0, 1, 1, 0, 32'h0, 0, 0), 204);
        apply(mk(0, 1, 8'h42, 0, 1, 1, 0, 32'h0, 0, 0), 205);
        apply(mk(0, 1, 8'h43, 0, 1, 1, 0, 32'h0, 0, 0), 206);
        apply(mk(0, 1, 8'h44, 0, 1, 1, 1, 32'h41424344, 4, 0), 207);
`else
        t = mk(0, 0, 8'h00, 0, 1, 1, 0, 32'h0, 0, 0);
        apply(t, 200);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
